// File: rtl/seven_seg_pkg.sv
// Shared 7-segment pattern/code constants and reader FSM states.
// Used by the forward decoder and by seven_seg_reader so both tables stay identical.
package seven_seg_pkg;

    // Active-low patterns, bit i = segment i (bit 0 top, bit 6 middle)
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    localparam logic [3:0] CODE_0     = 4'h0;
    localparam logic [3:0] CODE_1     = 4'h1;
    localparam logic [3:0] CODE_2     = 4'h2;
    localparam logic [3:0] CODE_3     = 4'h3;
    localparam logic [3:0] CODE_4     = 4'h4;
    localparam logic [3:0] CODE_5     = 4'h5;
    localparam logic [3:0] CODE_6     = 4'h6;
    localparam logic [3:0] CODE_7     = 4'h7;
    localparam logic [3:0] CODE_8     = 4'h8;
    localparam logic [3:0] CODE_9     = 4'h9;
    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_DASH  = 4'hB;
    localparam logic [3:0] CODE_H     = 4'hC;
    localparam logic [3:0] CODE_L     = 4'hD;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_P     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational inverse 7-seg table: pattern -> {code, err}.
// Unknown patterns report CODE_BLANK with err set.
module seg_pattern_lookup
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        code = CODE_BLANK;
        err  = 1'b0;
        case (seg)
            SEG_0:     code = CODE_0;
            SEG_1:     code = CODE_1;
            SEG_2:     code = CODE_2;
            SEG_3:     code = CODE_3;
            SEG_4:     code = CODE_4;
            SEG_5:     code = CODE_5;
            SEG_6:     code = CODE_6;
            SEG_7:     code = CODE_7;
            SEG_8:     code = CODE_8;
            SEG_9:     code = CODE_9;
            SEG_BLANK: code = CODE_BLANK;
            SEG_DASH:  code = CODE_DASH;
            SEG_H:     code = CODE_H;
            SEG_L:     code = CODE_L;
            SEG_E:     code = CODE_E;
            SEG_P:     code = CODE_P;
            default:   err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Monitors a multiplexed active-low 7-seg bus and recovers per-digit codes once stable.
// Optional decimal-point capture is enabled by defining SEVEN_SEG_READER_DP_EN.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 8,
    localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEVEN_SEG_READER_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dps,
    output logic                    upd_dp,
`endif
    output logic [4*NUM_DIGITS-1:0] codes,
    output logic [NUM_DIGITS-1:0]   code_err,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [IDX_W-1:0]        upd_digit,
    output logic [3:0]              upd_code,
    output logic                    upd_err,
    output logic                    frame_valid,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [6:0]            seg_q, seg_prev;
    logic [NUM_DIGITS-1:0] sel_q, sel_prev;
    logic                  same_sample;
    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic [3:0]            lk_code;
    logic                  lk_err;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  accept;
    logic [NUM_DIGITS-1:0] seen, seen_set;

    // Input stage plus one older copy for the stability compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q    <= '1;
            sel_q    <= '1;
            seg_prev <= '1;
            sel_prev <= '1;
        end else begin
            // NOTE: non-blocking so *_prev takes the old *_q value, giving a two-deep shift.
            seg_q    <= seg_in;
            sel_q    <= dig_sel_n;
            seg_prev <= seg_q;
            sel_prev <= sel_q;
        end
    end

`ifdef SEVEN_SEG_READER_DP_EN
    logic dp_q, dp_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_q    <= 1'b1;
            dp_prev <= 1'b1;
        end else begin
            dp_q    <= dp_n;
            dp_prev <= dp_q;
        end
    end

    assign same_sample = (seg_q == seg_prev) && (sel_q == sel_prev) && (dp_q == dp_prev);
`else
    assign same_sample = (seg_q == seg_prev) && (sel_q == sel_prev);
`endif

    always_comb begin
        sel_valid = ($countones(~sel_q) == 1);
        sel_idx   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!sel_q[k]) sel_idx = IDX_W'(k);
        end
    end

    seg_pattern_lookup u_lookup (
        .seg  (seg_q),
        .code (lk_code),
        .err  (lk_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt counts consecutive identical valid samples; HOLD parks it at STABLE_CYCLES
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_SETTLE;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!sel_valid) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (!same_sample) begin
                    cnt_next = CNT_W'(1);
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    accept     = 1'b1;
                    state_next = ST_HOLD;
                    cnt_next   = CNT_W'(STABLE_CYCLES);
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!sel_valid) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (!same_sample) begin
                    state_next = ST_SETTLE;
                    cnt_next   = CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        seen_set = seen;
        if (accept) seen_set[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the code bank is a few flops rather than a RAM, so it gets a defined blank reset.
            codes       <= {NUM_DIGITS{CODE_BLANK}};
            code_err    <= '0;
            upd_valid   <= 1'b0;
            upd_digit   <= '0;
            upd_code    <= '0;
            upd_err     <= 1'b0;
            overflow    <= 1'b0;
            seen        <= '0;
            frame_valid <= 1'b0;
        end else begin
            if (accept) begin
                codes[4*sel_idx +: 4] <= lk_code;
                code_err[sel_idx]     <= lk_err;
                upd_valid             <= 1'b1;
                upd_digit             <= sel_idx;
                upd_code              <= lk_code;
                upd_err               <= lk_err;
                if (upd_valid && !upd_ready) overflow <= 1'b1;
            end else if (upd_ready) begin
                upd_valid <= 1'b0;
            end
            frame_valid <= &seen_set;
            seen        <= (&seen_set) ? '0 : seen_set;
        end
    end

`ifdef SEVEN_SEG_READER_DP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dps    <= '0;
            upd_dp <= 1'b0;
        end else if (accept) begin
            dps[sel_idx] <= ~dp_q;
            upd_dp       <= ~dp_q;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed vector table, multi-cycle corner
// sequences, then random bus traffic checked every cycle against a run-length reference model.
module tb_seven_seg_reader;

    localparam int ND = 4;
    localparam int SC = 8;

    // Index = code; used by the reference model as the decode table
    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111,
        7'b0001001, 7'b1000111, 7'b0000110, 7'b0001100
    };
    localparam logic [6:0]    SEG_OFF  = 7'b1111111;
    localparam logic [ND-1:0] SEL_NONE = '1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [6:0]      seg_in = SEG_OFF;
    logic [ND-1:0]   dig_sel_n = SEL_NONE;
    logic            upd_ready = 1'b0;
    logic [4*ND-1:0] codes;
    logic [ND-1:0]   code_err;
    logic            upd_valid;
    logic [1:0]      upd_digit;
    logic [3:0]      upd_code;
    logic            upd_err;
    logic            frame_valid;
    logic            overflow;
`ifdef SEVEN_SEG_READER_DP_EN
    logic            dp_n = 1'b1;
    logic [ND-1:0]   dps;
    logic            upd_dp;
`endif

    int errors = 0;
    int checks = 0;

    seven_seg_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel_n   (dig_sel_n),
`ifdef SEVEN_SEG_READER_DP_EN
        .dp_n        (dp_n),
        .dps         (dps),
        .upd_dp      (upd_dp),
`endif
        .codes       (codes),
        .code_err    (code_err),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_digit   (upd_digit),
        .upd_code    (upd_code),
        .upd_err     (upd_err),
        .frame_valid (frame_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0]      m_reg_seg, m_prev_seg;
    logic [ND-1:0]   m_reg_sel, m_prev_sel;
    int              m_run;
    logic [4*ND-1:0] m_codes;
    logic [ND-1:0]   m_err;
    logic            m_uv;
    logic [1:0]      m_ud;
    logic [3:0]      m_uc;
    logic            m_ue;
    logic            m_ovf;
    logic [ND-1:0]   m_seen;
    logic            m_frame;

    typedef struct {
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        logic [1:0]    digit;
        logic [3:0]    code;
        logic          err;
        logic          frame;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int zeros(input logic [ND-1:0] s);
        int n = 0;
        for (int i = 0; i < ND; i++) if (!s[i]) n++;
        return n;
    endfunction

    function automatic int zero_pos(input logic [ND-1:0] s);
        int p = 0;
        for (int i = 0; i < ND; i++) if (!s[i]) p = i;
        return p;
    endfunction

    task automatic decode(input logic [6:0] p, output logic [3:0] c, output logic e);
        c = 4'hA;
        e = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (PAT[k] == p) begin
                c = 4'(k);
                e = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_reg_seg  = SEG_OFF;
        m_reg_sel  = SEL_NONE;
        m_prev_seg = SEG_OFF;
        m_prev_sel = SEL_NONE;
        m_run      = 0;
        m_codes    = 16'hAAAA;
        m_err      = '0;
        m_uv       = 1'b0;
        m_ud       = '0;
        m_uc       = '0;
        m_ue       = 1'b0;
        m_ovf      = 1'b0;
        m_seen     = '0;
        m_frame    = 1'b0;
    endtask

    // One clock edge: the sample captured at the previous edge is judged; a run of SC
    // identical valid samples produces exactly one accept.
    task automatic model_edge(input logic rst_v, input logic rdy, input logic [6:0] s, input logic [ND-1:0] sel);
        logic          acc;
        int            d;
        logic [3:0]    c;
        logic          e;
        logic [ND-1:0] seen_set;
        if (!rst_v) begin
            model_reset();
            return;
        end
        if (zeros(m_reg_sel) == 1) begin
            if (m_run > 0 && m_reg_seg == m_prev_seg && m_reg_sel == m_prev_sel) m_run++;
            else m_run = 1;
        end else begin
            m_run = 0;
        end
        acc = (m_run == SC);
        d   = zero_pos(m_reg_sel);
        decode(m_reg_seg, c, e);
        if (acc) begin
            m_codes[d*4 +: 4] = c;
            m_err[d]          = e;
            if (m_uv && !rdy) m_ovf = 1'b1;
            m_uv = 1'b1;
            m_ud = 2'(d);
            m_uc = c;
            m_ue = e;
        end else if (rdy) begin
            m_uv = 1'b0;
        end
        seen_set = m_seen;
        if (acc) seen_set[d] = 1'b1;
        if (&seen_set) begin
            m_frame = 1'b1;
            m_seen  = '0;
        end else begin
            m_frame = 1'b0;
            m_seen  = seen_set;
        end
        m_prev_seg = m_reg_seg;
        m_prev_sel = m_reg_sel;
        m_reg_seg  = s;
        m_reg_sel  = sel;
    endtask

    task automatic step(input logic [6:0] s, input logic [ND-1:0] sel, input logic rdy);
        seg_in    = s;
        dig_sel_n = sel;
        upd_ready = rdy;
        @(posedge clk);
        model_edge(rst_n, rdy, s, sel);
        #1;
        check("m_codes", 32'(codes), 32'(m_codes));
        check("m_code_err", 32'(code_err), 32'(m_err));
        check("m_upd", 32'({upd_valid, upd_digit, upd_code, upd_err}), 32'({m_uv, m_ud, m_uc, m_ue}));
        check("m_frame", 32'(frame_valid), 32'(m_frame));
        check("m_overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic hold(input logic [6:0] s, input logic [ND-1:0] sel, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(s, sel, rdy);
    endtask

    initial begin
        int            nupd;
        logic [ND-1:0] r_sel;
        logic [6:0]    r_seg;
        int            r_len;

        vecs[0] = '{4'b1011, 7'b0110000, 2'd2, 4'h3, 1'b0, 1'b0};
        vecs[1] = '{4'b1110, 7'b0100100, 2'd0, 4'h2, 1'b0, 1'b0};
        vecs[2] = '{4'b1101, 7'b0011001, 2'd1, 4'h4, 1'b0, 1'b0};
        vecs[3] = '{4'b1011, 7'b0000010, 2'd2, 4'h6, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 7'b0010000, 2'd3, 4'h9, 1'b0, 1'b1};
        vecs[5] = '{4'b1101, 7'b1110111, 2'd1, 4'hA, 1'b1, 1'b0};
        vecs[6] = '{4'b1110, 7'b0001001, 2'd0, 4'hC, 1'b0, 1'b0};
        vecs[7] = '{4'b0111, 7'b1000111, 2'd3, 4'hD, 1'b0, 1'b0};

        model_reset();

        // Reset state
        rst_n = 1'b0;
        hold(SEG_OFF, SEL_NONE, 1'b0, 2);
        check("rst_codes", 32'(codes), 32'hAAAA);
        check("rst_code_err", 32'(code_err), 32'h0);
        check("rst_upd", 32'({upd_valid, upd_digit, upd_code, upd_err}), 32'h0);
        check("rst_frame", 32'(frame_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;

        // Pattern flipping every 4 cycles never settles
        nupd = 0;
        for (int c = 0; c < 40; c++) begin
            step(((c / 4) % 2 != 0) ? 7'b0010000 : 7'b0000000, 4'b1110, 1'b1);
            if (upd_valid) nupd++;
        end
        check("toggle_updates", 32'(nupd), 32'd0);
        check("toggle_codes", 32'(codes), 32'hAAAA);

        // Vector table: each entry held SC+1 cycles lands exactly one update
        for (int i = 0; i < 8; i++) begin
            hold(vecs[i].seg, vecs[i].sel, 1'b1, SC);
            check($sformatf("tbl%0d_early", i), 32'(upd_valid), 32'd0);
            step(vecs[i].seg, vecs[i].sel, 1'b1);
            check($sformatf("tbl%0d_valid", i), 32'(upd_valid), 32'd1);
            check($sformatf("tbl%0d_digit", i), 32'(upd_digit), 32'(vecs[i].digit));
            check($sformatf("tbl%0d_code", i), 32'(upd_code), 32'(vecs[i].code));
            check($sformatf("tbl%0d_err", i), 32'(upd_err), 32'(vecs[i].err));
            check($sformatf("tbl%0d_frame", i), 32'(frame_valid), 32'(vecs[i].frame));
            if (i == 0) check("tbl0_digit2_code", 32'(codes[11:8]), 32'h3);
            if (i == 4) check("tbl4_frame_codes", 32'(codes), 32'h9642);
            if (i == 5) check("tbl5_code_err", 32'(code_err), 32'b0010);
            step(vecs[i].seg, vecs[i].sel, 1'b1);
            check($sformatf("tbl%0d_consumed", i), 32'(upd_valid), 32'd0);
        end

        // Overwrite of an unconsumed update sets sticky overflow
        hold(7'b0000000, 4'b1110, 1'b0, SC + 1);
        check("ovf_first_code", 32'(upd_code), 32'h8);
        check("ovf_first_flag", 32'(overflow), 32'd0);
        hold(7'b0000110, 4'b1101, 1'b0, SC + 1);
        check("ovf_second", 32'({upd_valid, upd_digit, upd_code}), 32'({1'b1, 2'd1, 4'hE}));
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_codes_lo", 32'(codes[7:0]), 32'hE8);
        hold(7'b0000110, 4'b1101, 1'b0, 5);
        check("ovf_sticky", 32'(overflow), 32'd1);
        step(7'b0000110, 4'b1101, 1'b1);
        check("ovf_drained", 32'(upd_valid), 32'd0);
        check("ovf_kept", 32'(overflow), 32'd1);

        // Reset in the middle of settling (cnt=5), then a full STABLE_CYCLES is needed again
        hold(7'b0010010, 4'b0111, 1'b1, 6);
        rst_n = 1'b0;
        step(7'b0010010, 4'b0111, 1'b1);
        check("mid_rst_codes", 32'(codes), 32'hAAAA);
        check("mid_rst_code_err", 32'(code_err), 32'h0);
        check("mid_rst_upd", 32'({upd_valid, upd_digit, upd_code, upd_err}), 32'h0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_frame", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;
        hold(7'b0010010, 4'b0111, 1'b1, SC);
        check("mid_rst_no_early", 32'(upd_valid), 32'd0);
        step(7'b0010010, 4'b0111, 1'b1);
        check("mid_rst_accept", 32'({upd_valid, upd_digit, upd_code, upd_err}), 32'({1'b1, 2'd3, 4'h5, 1'b0}));
        check("mid_rst_codes_after", 32'(codes), 32'h5AAA);

        // Random bus traffic against the model
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 99) < 85) r_sel = ~(ND'(1) << $urandom_range(0, ND - 1));
            else r_sel = ND'($urandom);
            if ($urandom_range(0, 99) < 80) r_seg = PAT[$urandom_range(0, 15)];
            else r_seg = 7'($urandom);
            r_len = $urandom_range(1, 14);
            for (int k = 0; k < r_len; k++) step(r_seg, r_sel, ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
